// File: rtl/i2c_transfer_sequencer.sv
// i2c_transfer_sequencer
//   Control FSM that runs a single I2C register write in this order:
//   START, address byte, ACK, register byte, ACK, data byte, ACK, STOP.
//   It drives the byte engine's send strobes and the SDA pad. The SCL
//   generator is gated through scl_enable.
// Ports
//   clock, reset (sync, active low)     : clocking
//   timebase                            : SCL-rate timebase, rising edge = bit slot
//   request_valid/ready, request_*      : write request handshake and fields
//   engine_*, send_*                    : latched fields and send strobes to byte engine
//   engine_transfer_done, engine_sda    : byte engine status and serial bit
//   i2c_sda_in/out/oe                   : SDA pad (oe=0 releases the line)
//   scl_enable                          : SCL generator gate
//   busy, done, nack                    : transfer status
module i2c_transfer_sequencer #(
  parameter int SETUP_DELAY = 35
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       timebase,
  input  logic       request_valid,
  output logic       request_ready,
  input  logic [6:0] request_slave_address,
  input  logic [7:0] request_register,
  input  logic [7:0] request_data,
  output logic [6:0] engine_slave_address,
  output logic [7:0] engine_register,
  output logic [7:0] engine_data,
  output logic       engine_direction,
  output logic       send_slave_address,
  output logic       send_register,
  output logic       send_data,
  input  logic       engine_transfer_done,
  input  logic       engine_sda,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_out,
  output logic       i2c_sda_oe,
  output logic       scl_enable,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int DW = $clog2(SETUP_DELAY + 1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(SETUP_DELAY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK_A, S_REG, S_ACK_R, S_DATA, S_ACK_D, S_STOP
  } state_t;

  state_t         state, next_state;
  logic           previous_timebase;
  logic           entered;       // first cycle in the current state
  logic           byte_done;     // engine finished this byte, waiting for the slot edge
  logic           stop_counting; // STOP: SCL hold tick is over, now counting the setup delay
  logic [DW-1:0]  delay_count;
  logic           tick;
  logic           accept;
  logic           in_byte, in_ack;

  assign tick    = timebase & ~previous_timebase;
  assign accept  = request_valid & request_ready;
  assign in_byte = (state == S_ADDR) || (state == S_REG) || (state == S_DATA);
  assign in_ack  = (state == S_ACK_A) || (state == S_ACK_R) || (state == S_ACK_D);

  // State register and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state                <= S_IDLE;
      previous_timebase    <= 1'b0;
      entered              <= 1'b0;
      byte_done            <= 1'b0;
      stop_counting        <= 1'b0;
      delay_count          <= '0;
      done                 <= 1'b0;
      nack                 <= 1'b0;
      engine_slave_address <= '0;
      engine_register      <= '0;
      engine_data          <= '0;
    end else begin
      state             <= next_state;
      previous_timebase <= timebase;
      entered           <= (next_state != state);
      done              <= (state == S_STOP) && (next_state == S_IDLE);

      if (next_state != state)
        delay_count <= '0;
      else if ((state == S_START) || ((state == S_STOP) && stop_counting))
        delay_count <= delay_count + DW'(1);

      // A done arriving together with the slot edge advances on that edge,
      // so remembering it is only needed when it comes early.
      if (next_state != state)
        byte_done <= 1'b0;
      else if (in_byte && engine_transfer_done)
        byte_done <= 1'b1;

      if (state != S_STOP)
        stop_counting <= 1'b0;
      else if (tick)
        stop_counting <= 1'b1;

      if (accept)
        nack <= 1'b0;
      else if (in_ack && tick && i2c_sda_in)
        nack <= 1'b1;

      if (accept) begin
        engine_slave_address <= request_slave_address;
        engine_register      <= request_register;
        engine_data          <= request_data;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (request_valid) next_state = S_START;
      S_START: if (delay_count == DELAY_LAST) next_state = S_ADDR;
      S_ADDR:  if (tick && (byte_done || engine_transfer_done)) next_state = S_ACK_A;
      S_ACK_A: if (tick) next_state = i2c_sda_in ? S_STOP : S_REG;
      S_REG:   if (tick && (byte_done || engine_transfer_done)) next_state = S_ACK_R;
      S_ACK_R: if (tick) next_state = i2c_sda_in ? S_STOP : S_DATA;
      S_DATA:  if (tick && (byte_done || engine_transfer_done)) next_state = S_ACK_D;
      S_ACK_D: if (tick) next_state = S_STOP;
      S_STOP:  if (stop_counting && (delay_count == DELAY_LAST)) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    request_ready      = (state == S_IDLE);
    busy               = (state != S_IDLE);
    engine_direction   = 1'b0;
    send_slave_address = entered && (state == S_ADDR);
    send_register      = entered && (state == S_REG);
    send_data          = entered && (state == S_DATA);
    scl_enable         = in_byte || in_ack || ((state == S_STOP) && !stop_counting);
    i2c_sda_oe         = 1'b0;
    i2c_sda_out        = 1'b1;
    if (state == S_START || state == S_STOP) begin
      i2c_sda_oe  = 1'b1;
      i2c_sda_out = 1'b0;
    end else if (in_byte) begin
      i2c_sda_oe  = 1'b1;
      i2c_sda_out = engine_sda;
    end
  end

endmodule
